// File: rtl/freq_packet_tx.sv
// freq_packet_tx: frames a captured measurement word as SYNC_BYTE followed
// by the data bytes MSB-first and feeds them one at a time to a byte UART.
// Optional trailing XOR checksum byte when FREQ_PACKET_TX_CHECKSUM_EN is defined.
// Ports:
//   clk, rst (sync, active-low)     : clock / reset
//   start, data                     : packet request and measurement word
//   tx_busy                         : UART busy flag
//   tx_ena, txbyte                  : UART load strobe and byte
//   busy, pkt_done, dropped, ack_err: status (pulses are one cycle)
module freq_packet_tx #(
   parameter int         DATA_BYTES  = 2,
   parameter logic [7:0] SYNC_BYTE   = 8'hA5,
   parameter int         GAP_CYCLES  = 1000,
   parameter int         ACK_TIMEOUT = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [8*DATA_BYTES-1:0] data,
   input  logic                    tx_busy,
   output logic                    tx_ena,
   output logic [7:0]              txbyte,
   output logic                    busy,
   output logic                    pkt_done,
   output logic                    dropped,
   output logic                    ack_err
);

`ifdef FREQ_PACKET_TX_CHECKSUM_EN
   localparam int NBYTES = DATA_BYTES + 2;
`else
   localparam int NBYTES = DATA_BYTES + 1;
`endif
   localparam int IW = $clog2(NBYTES + 1);
   localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam int TW = $clog2(ACK_TIMEOUT + 1);

   localparam logic [IW-1:0] IDX_LAST = IW'(NBYTES - 1);
   localparam logic [GW-1:0] GAP_LAST =
      GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [TW-1:0] TO_LAST  = TW'(ACK_TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE, LOAD, STROBE, WAIT_ACK, WAIT_DONE, GAP
   } state_t;

   state_t                  state_q, state_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [8*DATA_BYTES-1:0] shadow_q, shadow_d;
   logic [7:0]              txbyte_q, txbyte_d;
   logic [GW-1:0]           gap_q, gap_d;
   logic [TW-1:0]           to_q, to_d;

   // Byte i of the packet: 0 is the header, then data MSB-first.
   function automatic logic [7:0] pick(
      input logic [IW-1:0]           i,
      input logic [8*DATA_BYTES-1:0] d
   );
      logic [7:0] b;
`ifdef FREQ_PACKET_TX_CHECKSUM_EN
      logic [7:0] c;
      c = 8'h00;
      for (int k = 0; k < DATA_BYTES; k++) c ^= d[8*k +: 8];
`endif
      b = SYNC_BYTE;
      for (int k = 0; k < DATA_BYTES; k++)
         if (i == IW'(k + 1)) b = d[8*(DATA_BYTES-k)-1 -: 8];
`ifdef FREQ_PACKET_TX_CHECKSUM_EN
      if (i == IW'(DATA_BYTES + 1)) b = c;
`endif
      return b;
   endfunction

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      shadow_d = shadow_q;
      txbyte_d = txbyte_q;
      gap_d    = gap_q;
      to_d     = to_q;
      pkt_done = 1'b0;
      ack_err  = 1'b0;
      busy     = (state_q != IDLE);
      tx_ena   = (state_q == STROBE);
      dropped  = start && (state_q != IDLE);
      unique case (state_q)
         IDLE: begin
            if (start) begin
               shadow_d = data;
               idx_d    = '0;
               // txbyte is loaded on entry to LOAD so it is already
               // valid while LOAD is the current state.
               txbyte_d = pick('0, data);
               state_d  = LOAD;
            end
         end
         LOAD:   state_d = STROBE;
         STROBE: begin
            to_d    = '0;
            state_d = WAIT_ACK;
         end
         WAIT_ACK: begin
            if (tx_busy) begin
               state_d = WAIT_DONE;
            end else if (to_q == TO_LAST) begin
               ack_err = 1'b1;
               state_d = IDLE;
            end else begin
               to_d = to_q + 1'b1;
            end
         end
         WAIT_DONE: begin
            if (!tx_busy) begin
               gap_d   = '0;
               state_d = GAP;
            end
         end
         GAP: begin
            if (gap_q == GAP_LAST) begin
               if (idx_q == IDX_LAST) begin
                  pkt_done = 1'b1;
                  state_d  = IDLE;
               end else begin
                  idx_d    = idx_q + 1'b1;
                  txbyte_d = pick(idx_q + 1'b1, shadow_q);
                  state_d  = LOAD;
               end
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      // Reset dominates: no strobes or pulses escape during a reset cycle.
      if (!rst) begin
         tx_ena   = 1'b0;
         pkt_done = 1'b0;
         ack_err  = 1'b0;
         dropped  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         shadow_q <= '0;
         txbyte_q <= 8'h00;
         gap_q    <= '0;
         to_q     <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         shadow_q <= shadow_d;
         txbyte_q <= txbyte_d;
         gap_q    <= gap_d;
         to_q     <= to_d;
      end
   end

   assign txbyte = txbyte_q;

endmodule

// File: tb/tb_freq_packet_tx.sv
// tb_freq_packet_tx: randomized bench for freq_packet_tx with a cycle-level
// behavioural model, a UART stand-in and a few literal packet expectations.
module tb_freq_packet_tx;

   localparam int DB  = 2;
   localparam int GAP = 4;
   localparam int ATO = 16;
`ifdef FREQ_PACKET_TX_CHECKSUM_EN
   localparam int NB  = DB + 2;
   localparam int NB4 = 6;
`else
   localparam int NB  = DB + 1;
   localparam int NB4 = 5;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [15:0] data = '0;
   logic        tx_busy = 1'b0;
   logic        tx_ena, busy, pkt_done, dropped, ack_err;
   logic [7:0]  txbyte;

   logic        start4 = 1'b0;
   logic [31:0] data4 = '0;
   logic        tx_busy4 = 1'b0;
   logic        tx_ena4, busy4, pkt_done4, dropped4, ack_err4;
   logic [7:0]  txbyte4;

   freq_packet_tx #(.DATA_BYTES(DB), .SYNC_BYTE(8'hA5),
                    .GAP_CYCLES(GAP), .ACK_TIMEOUT(ATO)) u_dut (
      .clk(clk), .rst(rst), .start(start), .data(data),
      .tx_busy(tx_busy), .tx_ena(tx_ena), .txbyte(txbyte),
      .busy(busy), .pkt_done(pkt_done), .dropped(dropped),
      .ack_err(ack_err));

   freq_packet_tx #(.DATA_BYTES(4), .SYNC_BYTE(8'hA5),
                    .GAP_CYCLES(0), .ACK_TIMEOUT(16)) u_dut4 (
      .clk(clk), .rst(rst), .start(start4), .data(data4),
      .tx_busy(tx_busy4), .tx_ena(tx_ena4), .txbyte(txbyte4),
      .busy(busy4), .pkt_done(pkt_done4), .dropped(dropped4),
      .ack_err(ack_err4));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // model state
   bit         m_active = 0;
   logic [7:0] m_q[$];
   int         exp_ena = -1, exp_done = -1, exp_err = -1;
   int         u_from = 1, u_to = 0;
   int         st_from = 1, st_to = 0;
   logic [7:0] st_byte = '0;
   bit         post_rst = 0;
   bit         rnd = 0, mute = 0;
   logic [7:0] obs[$];
   int         pd_cnt = 0, ae_cnt = 0, dr_cnt = 0;
   int         ena_cyc = 0, err_cyc = 0;

   logic [7:0] obs4[$];
   int         ena4[$];
   int         pd4 = 0, u4_from = 1, u4_to = 0;

   task automatic chk(string n, logic [31:0] a, logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // UART stand-ins: busy window scheduled by the model at each strobe
   always @(posedge clk) begin
      #1;
      tx_busy  = (cyc >= u_from) && (cyc <= u_to);
      tx_busy4 = (cyc >= u4_from) && (cyc <= u4_to);
   end

   always @(negedge clk) begin : cmp
      int lat, b, f;
      bit acc;
      if (post_rst) begin
         chk("rst_busy", 32'(busy), 0);
         chk("rst_txbyte", 32'(txbyte), 0);
         post_rst = 0;
      end
      if (!rst) begin
         chk("rst_tx_ena", 32'(tx_ena), 0);
         chk("rst_pkt_done", 32'(pkt_done), 0);
         chk("rst_dropped", 32'(dropped), 0);
         chk("rst_ack_err", 32'(ack_err), 0);
         m_active = 0;
         m_q.delete();
         exp_ena = -1; exp_done = -1; exp_err = -1;
         u_from = 1; u_to = 0; st_from = 1; st_to = 0;
         post_rst = 1;
      end else begin
         chk("busy", 32'(busy), 32'(m_active));
         chk("tx_ena", 32'(tx_ena), 32'(cyc == exp_ena));
         chk("pkt_done", 32'(pkt_done), 32'(cyc == exp_done));
         chk("ack_err", 32'(ack_err), 32'(cyc == exp_err));
         chk("dropped", 32'(dropped), 32'(start && m_active));
         if (cyc == exp_ena - 1 && m_q.size() > 0)
            chk("load_byte", 32'(txbyte), 32'(m_q[0]));
         if (cyc > st_from && cyc <= st_to)
            chk("txbyte_hold", 32'(txbyte), 32'(st_byte));
         if (tx_ena) begin
            obs.push_back(txbyte);
            ena_cyc = cyc;
         end
         if (cyc == exp_ena && m_q.size() > 0) begin
            chk("txbyte", 32'(txbyte), 32'(m_q.pop_front()));
            if (rnd) begin
               lat = $urandom_range(0, 3);
               b   = $urandom_range(1, 12);
            end else begin
               lat = 0;
               b   = 10;
            end
            if (mute) begin
               exp_err = cyc + ATO;
               u_from = 1; u_to = 0;
            end else begin
               u_from = cyc + 1 + lat;
               u_to   = cyc + lat + b;
               f      = cyc + 1 + lat + b;
               st_from = cyc; st_to = f; st_byte = txbyte;
               if (m_q.size() == 0) exp_done = f + GAP;
               else exp_ena = f + GAP + 2;
            end
         end
         if (pkt_done) pd_cnt++;
         if (dropped) dr_cnt++;
         if (ack_err) begin
            ae_cnt++;
            err_cyc = cyc;
         end
         acc = start && !m_active;
         if (cyc == exp_done || cyc == exp_err) m_active = 0;
         if (acc) begin : accept
            logic [7:0] cs;
            cs = 8'h00;
            m_q.delete();
            m_q.push_back(8'hA5);
            for (int k = DB - 1; k >= 0; k--) begin
               m_q.push_back(data[8*k +: 8]);
               cs ^= data[8*k +: 8];
            end
`ifdef FREQ_PACKET_TX_CHECKSUM_EN
            m_q.push_back(cs);
`endif
            exp_ena  = cyc + 2;
            m_active = 1;
         end
      end
   end

   always @(negedge clk) begin
      if (tx_ena4) begin
         obs4.push_back(txbyte4);
         ena4.push_back(cyc);
         u4_from = cyc + 1;
         u4_to   = cyc + 3;
      end
      if (pkt_done4) pd4++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(int budget);
      int n;
      n = 0;
      step();
      while ((busy || m_active) && n < budget) begin
         step();
         n++;
      end
      checks++;
      if (busy || m_active) begin
         errors++;
         $display("FAIL wait_idle: busy=%0b expected idle", busy);
      end
   endtask

   initial begin : stim
      logic [7:0] ea[4];
      logic [7:0] eb[4];
      logic [7:0] ee[4];
      logic [7:0] e4[6];
      int pd0, dr0, ae0, n;
      ea = '{8'hA5, 8'h12, 8'h34, 8'h26};
      eb = '{8'hA5, 8'hBE, 8'hEF, 8'h51};
      ee = '{8'hA5, 8'h55, 8'h00, 8'h55};
      e4 = '{8'hA5, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
             8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF};

      repeat (3) step();
      rst = 1;
      step();

      // directed packet on both instances
      obs.delete();
      data = 16'h1234; start = 1;
      data4 = 32'hDEADBEEF; start4 = 1;
      step();
      start = 0; start4 = 0; data = 16'h0;
      wait_idle(500);
      chk("a_len", 32'(obs.size()), 32'(NB));
      for (int i = 0; i < NB && i < obs.size(); i++)
         chk("a_byte", 32'(obs[i]), 32'(ea[i]));
      chk("a_pkt_done", 32'(pd_cnt), 1);
      repeat (20) step();
      chk("d4_len", 32'(obs4.size()), 32'(NB4));
      for (int i = 0; i < NB4 && i < obs4.size(); i++)
         chk("d4_byte", 32'(obs4[i]), 32'(e4[i]));
      for (int i = 1; i < ena4.size(); i++)
         chk("d4_spacing", 32'(ena4[i] - ena4[i-1]), 7);
      chk("d4_pkt_done", 32'(pd4), 1);

      // start while busy is dropped, data unchanged
      obs.delete();
      pd0 = pd_cnt; dr0 = dr_cnt;
      data = 16'hBEEF; start = 1;
      step();
      start = 0;
      repeat (20) step();
      data = 16'h5555; start = 1;
      step();
      start = 0;
      wait_idle(500);
      chk("b_len", 32'(obs.size()), 32'(NB));
      for (int i = 0; i < NB && i < obs.size(); i++)
         chk("b_byte", 32'(obs[i]), 32'(eb[i]));
      chk("b_dropped", 32'(dr_cnt - dr0), 1);
      chk("b_pkt_done", 32'(pd_cnt - pd0), 1);

      // silent UART -> ack timeout
      pd0 = pd_cnt; ae0 = ae_cnt;
      mute = 1;
      data = 16'h0F0F; start = 1;
      step();
      start = 0;
      wait_idle(200);
      mute = 0;
      chk("c_ack_err", 32'(ae_cnt - ae0), 1);
      chk("c_err_delay", 32'(err_cyc - ena_cyc), 16);
      chk("c_pkt_done", 32'(pd_cnt - pd0), 0);

      // reset while the second byte is in flight
      obs.delete();
      data = 16'hCAFE; start = 1;
      step();
      start = 0;
      n = 0;
      while (obs.size() < 2 && n < 200) begin
         step();
         n++;
      end
      chk("d_reached_byte2", 32'(obs.size()), 2);
      repeat (2) step();
      rst = 0;
      step();
      rst = 1;
      repeat (40) step();
      chk("d_no_tx_after_rst", 32'(obs.size()), 2);

      // start on the pkt_done cycle is dropped, next cycle accepted
      data = 16'h0102; start = 1;
      step();
      start = 0;
      n = 0;
      while (exp_done != cyc && n < 300) begin
         step();
         n++;
      end
      chk("e_reached_done", 32'(exp_done == cyc), 1);
      dr0 = dr_cnt;
      obs.delete();
      data = 16'hAAAA; start = 1;
      step();
      data = 16'h5500;
      step();
      start = 0;
      wait_idle(500);
      chk("e_dropped", 32'(dr_cnt - dr0), 1);
      chk("e_len", 32'(obs.size()), 32'(NB));
      for (int i = 0; i < NB && i < obs.size(); i++)
         chk("e_byte", 32'(obs[i]), 32'(ee[i]));

      // randomized traffic
      rnd = 1;
      for (int i = 0; i < 4000; i++) begin
         start = ($urandom_range(0, 59) == 0);
         data  = 16'($urandom);
         mute  = ($urandom_range(0, 19) == 0);
         step();
      end
      start = 0; mute = 0;
      wait_idle(500);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
